// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative shift-add multiplier.
//   Opcodes (sel): 00 MUL, 01 SUB, 10 AND, 11 XOR. B is zero-extended to
//   WIDTH_A for SUB/AND/XOR. SUB/AND/XOR finish at the accept edge; MUL
//   iterates one bit of B per cycle for WIDTH_B cycles.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          request, sampled only while idle
//   A [WIDTH_A]    operand A, captured on accept
//   B [WIDTH_B]    operand B, captured on accept
//   sel [2]        opcode, captured on accept
//   busy           high while a MUL is iterating
//   done           one-cycle pulse after Y/flags are written
//   Y [WIDTH_A]    registered result
//   Z, N, C, V     registered zero / negative / carry-borrow / overflow flags
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready; accepts start, single-cycle ops complete here
// S_MUL  | multiplier iterating over bits of the captured B
module alu_seq #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic [1:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] Y,
    output logic               Z,
    output logic               N,
    output logic               C,
    output logic               V
);
    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH_B - 1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH_A-1:0] a_q, a_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      p_q, p_d;
    logic [WIDTH_A-1:0] y_q, y_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic               done_q, done_d;

    logic [WIDTH_A-1:0] b_ext;
    logic [WIDTH_A:0]   diff;
    logic [WIDTH_B-1:0] b_shift;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      p_sum;

    logic               wr;
    logic [WIDTH_A-1:0] res_y;
    logic               res_c, res_v;

    assign b_ext = WIDTH_A'(B);
    // Extra MSB of the difference is the unsigned borrow.
    assign diff  = {1'b0, A} - {1'b0, b_ext};

    // Partial product for the current bit of the captured B.
    assign b_shift = b_q >> cnt_q;
    assign addend  = b_shift[0] ? (PW'(a_q) << cnt_q) : '0;
    assign p_sum   = p_q + addend;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        y_d     = y_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d = A;
                    b_d = B;
                    case (sel)
                        OP_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            p_d     = '0;
                        end
                        OP_SUB: begin
                            wr    = 1'b1;
                            res_y = diff[WIDTH_A-1:0];
                            res_c = diff[WIDTH_A];
                            res_v = (A[WIDTH_A-1] != b_ext[WIDTH_A-1]) &&
                                    (diff[WIDTH_A-1] != A[WIDTH_A-1]);
                        end
                        OP_AND: begin
                            wr    = 1'b1;
                            res_y = A & b_ext;
                        end
                        OP_XOR: begin
                            wr    = 1'b1;
                            res_y = A ^ b_ext;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                p_d   = p_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wr      = 1'b1;
                    res_y   = p_sum[WIDTH_A-1:0];
                    // Any bit above the result width means the product was truncated.
                    res_c   = |p_sum[PW-1:WIDTH_A];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr) begin
            y_d    = res_y;
            z_d    = (res_y == '0);
            n_d    = res_y[WIDTH_A-1];
            c_d    = res_c;
            v_d    = res_v;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            y_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            y_q     <= y_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_MUL);
    assign done = done_q;
    assign Y    = y_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign C    = c_q;
    assign V    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized bench for alu_seq, with one instance
// at the default widths (4/2) and one at 8/4. Expected results come from
// plain integer arithmetic on the operands.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;

    logic       start4, busy4, done4, Z4, N4, C4, V4;
    logic [3:0] A4, Y4;
    logic [1:0] B4, sel4;

    logic       start8, busy8, done8, Z8, N8, C8, V8;
    logic [7:0] A8, Y8;
    logic [3:0] B8;
    logic [1:0] sel8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH_A(4), .WIDTH_B(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4), .sel(sel4),
        .busy(busy4), .done(done4), .Y(Y4), .Z(Z4), .N(N4), .C(C4), .V(V4)
    );

    alu_seq #(.WIDTH_A(8), .WIDTH_B(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .sel(sel8),
        .busy(busy8), .done(done8), .Y(Y8), .Z(Z8), .N(N8), .C(C8), .V(V8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status word: [5] busy, [4] done, [3] Z, [2] N, [1] C, [0] V
    function automatic logic [31:0] rd_st(input int w);
        if (w == 4) return {26'b0, busy4, done4, Z4, N4, C4, V4};
        return {26'b0, busy8, done8, Z8, N8, C8, V8};
    endfunction

    function automatic logic [31:0] rd_y(input int w);
        if (w == 4) return {28'b0, Y4};
        return {24'b0, Y8};
    endfunction

    task automatic set_in(input int w, input logic st, input int a, input int b, input int s);
        if (w == 4) begin
            start4 = st; A4 = 4'(a); B4 = 2'(b); sel4 = 2'(s);
        end else begin
            start8 = st; A8 = 8'(a); B8 = 4'(b); sel8 = 2'(s);
        end
    endtask

    // Reference: integer arithmetic; f = {Z, N, C, V}
    function automatic void model(input int w, input int a, input int b, input int s,
                                  output int y, output logic [3:0] f);
        int m, full, sa, sb, sd;
        logic c, v;
        m = 1 << w;
        c = 1'b0;
        v = 1'b0;
        case (s)
            0: begin
                full = a * b;
                y = full % m;
                c = (full >= m);
            end
            1: begin
                y  = (a - b + m) % m;
                c  = (a < b);
                sa = (a >= m / 2) ? a - m : a;
                sb = (b >= m / 2) ? b - m : b;
                sd = sa - sb;
                v  = (sd < -(m / 2)) || (sd >= m / 2);
            end
            2: y = a & b;
            default: y = a ^ b;
        endcase
        f = {(y == 0), (y >= m / 2), c, v};
    endfunction

    task automatic run_op(input int w, input int a, input int b, input int s, input string tag);
        int wb, k, nb, ey;
        logic [3:0]  ef;
        logic [31:0] st;
        wb = (w == 4) ? 2 : 4;
        model(w, a, b, s, ey, ef);
        set_in(w, 1'b1, a, b, s);
        tick();
        set_in(w, 1'b0, int'($urandom), int'($urandom), int'($urandom));
        k  = 0;
        nb = 0;
        st = rd_st(w);
        while (!st[4] && k < 40) begin
            if (st[5]) nb++;
            tick();
            k++;
            st = rd_st(w);
        end
        check({tag, "_latency"}, k, (s == 0) ? wb : 0);
        check({tag, "_busy_cycles"}, nb, (s == 0) ? wb : 0);
        check({tag, "_y"}, rd_y(w), ey);
        check({tag, "_busy_zn_cv"}, {27'b0, st[5], st[3:0]}, {28'b0, ef});
        tick();
        st = rd_st(w);
        check({tag, "_done_pulse"}, {31'b0, st[4]}, 0);
        check({tag, "_y_hold"}, rd_y(w), ey);
    endtask

    initial begin
        logic [31:0] st;
        int k;
        logic seen;

        rst_n = 1'b0;
        set_in(4, 1'b0, 0, 0, 0);
        set_in(8, 1'b0, 0, 0, 0);
        #12;
        check("reset4_status", rd_st(4), 0);
        check("reset4_y", rd_y(4), 0);
        check("reset8_status", rd_st(8), 0);
        check("reset8_y", rd_y(8), 0);
        #11 rst_n = 1'b1;
        tick();
        check("post_reset4_status", rd_st(4), 0);
        check("post_reset8_status", rd_st(8), 0);

        run_op(4, 7, 3, 0, "mul_7x3");
        check("mul_7x3_const_y", rd_y(4), 5);
        run_op(4, 3, 2, 0, "mul_3x2");
        check("mul_3x2_const_y", rd_y(4), 6);

        // Asynchronous reset mid-cycle clears outputs immediately
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_y", rd_y(4), 0);
        check("async_reset_status", rd_st(4), 0);
        #2 rst_n = 1'b1;
        tick();
        check("async_reset_busy_after", rd_st(4), 0);

        run_op(4, 2, 3, 1, "sub_2m3");
        run_op(4, 8, 1, 1, "sub_8m1");
        check("sub_8m1_const_v", {31'b0, V4}, 1);
        run_op(4, 3, 3, 1, "sub_3m3");
        run_op(4, 0, 0, 0, "mul_b0");

        // AND then XOR with start held: two consecutive done pulses
        set_in(4, 1'b1, 'hC, 3, 2);
        tick();
        st = rd_st(4);
        check("b2b_and_done", {31'b0, st[4]}, 1);
        check("b2b_and_y", rd_y(4), 0);
        check("b2b_and_z", {31'b0, st[3]}, 1);
        set_in(4, 1'b1, 5, 2, 3);
        tick();
        st = rd_st(4);
        check("b2b_xor_done", {31'b0, st[4]}, 1);
        check("b2b_xor_y", rd_y(4), 7);
        set_in(4, 1'b0, 0, 0, 0);
        tick();
        st = rd_st(4);
        check("b2b_done_low", {31'b0, st[4]}, 0);

        // start while busy is ignored and not queued
        set_in(4, 1'b1, 7, 3, 0);
        tick();
        set_in(4, 1'b1, 1, 0, 1);
        k  = 0;
        st = rd_st(4);
        while (!st[4] && k < 40) begin
            tick();
            k++;
            st = rd_st(4);
        end
        set_in(4, 1'b0, 0, 0, 0);
        check("busy_ign_latency", k, 2);
        check("busy_ign_y", rd_y(4), 5);
        check("busy_ign_c", {31'b0, st[1]}, 1);
        tick();
        st = rd_st(4);
        check("busy_ign_no_queue_done", {31'b0, st[4]}, 0);
        check("busy_ign_no_queue_y", rd_y(4), 5);

        // Reset during MUL aborts it: no done, Y stays cleared
        set_in(4, 1'b1, 3, 3, 0);
        tick();
        set_in(4, 1'b0, 0, 0, 0);
        st = rd_st(4);
        check("abort_busy_before", {31'b0, st[5]}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_y", rd_y(4), 0);
        check("abort_status", rd_st(4), 0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            st = rd_st(4);
            if (st[4] || st[5]) seen = 1'b1;
        end
        check("abort_no_done_or_busy", {31'b0, seen}, 0);
        check("abort_y_after", rd_y(4), 0);

        for (int i = 0; i < 60; i++)
            run_op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), "rnd4");

        run_op(8, 'hFF, 'hF, 0, "mul8_ff_f");
        check("mul8_const_y", rd_y(8), 'hF1);
        check("mul8_const_c", {31'b0, C8}, 1);
        run_op(8, 0, 1, 1, "sub8_0m1");
        check("sub8_const_y", rd_y(8), 'hFF);

        for (int i = 0; i < 40; i++)
            run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), "rnd8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU.
- Same opcode map: 00 MUL, 01 SUB, 10 AND, 11 XOR. Same flags: Z, N, C, V.
- Operand widths are generic. MUL is an iterative shift-add unit taking WIDTH_B cycles. All other ops complete in one cycle.
- Sits between the operand/switch capture logic and the display/flag registers, with a start/busy/done handshake.

Parameters:
- WIDTH_A, 4, width of operand A and of result Y (>=2).
- WIDTH_B, 2, width of operand B (1..WIDTH_A); B is zero-extended to WIDTH_A for SUB/AND/XOR.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- A  in  WIDTH_A  operand A, captured on accept.
- B  in  WIDTH_B  operand B, captured on accept.
- sel  in  2  opcode, captured on accept.
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse: Y and flags just updated.
- Y  out  WIDTH_A  registered result.
- Z  out  1  registered zero flag.
- N  out  1  registered negative flag.
- C  out  1  registered carry/borrow flag.
- V  out  1  registered overflow flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Y=0, Z=0, N=0, C=0, V=0, busy=0, done=0; multiplier accumulator and counter cleared. Asserting reset mid-MUL aborts the operation; no done pulse follows.
- States: IDLE, MUL.
- Accept: rising edge with state=IDLE and start=1. A, B and sel are latched at that edge. start while busy=1 is ignored and not queued.
- done defaults to 0 every cycle. It is 1 only in the cycle after an edge that writes Y/flags.
- SUB/AND/XOR, from IDLE on accept:
  - Y/flags are written at the accept edge and done=1 in the next cycle. Latency 1.
  - State stays IDLE, so a new start is accepted in the done cycle (back-to-back, one result per cycle).
- MUL, from IDLE on accept:
  - Go to MUL; busy=1 from the next cycle; iteration count cnt=0; accumulator P (WIDTH_A+WIDTH_B bits) = 0.
  - Each edge in MUL: if B[cnt]=1, add (A << cnt) to P; then cnt++.
  - On the edge processing cnt=WIDTH_B-1: write Y/flags, return to IDLE, clear busy.
  - done=1 in the cycle after edge E0+WIDTH_B, where E0 is the accept edge. Latency WIDTH_B.
  - MUL with B=0 still takes WIDTH_B cycles.
- Arithmetic rules:
  - MUL: Y = P[WIDTH_A-1:0]; C = OR of P[WIDTH_A+WIDTH_B-1:WIDTH_A] (result truncated); V=0.
  - SUB: Y = A - zext(B), mod 2^WIDTH_A. C=1 iff A < zext(B) as unsigned (borrow). V=1 iff A[msb] != zext(B)[msb] and Y[msb] != A[msb].
  - AND: Y = A & zext(B); C=0, V=0.
  - XOR: Y = A ^ zext(B); C=0, V=0.
  - All ops: Z = (Y==0); N = Y[msb].
- Y and flags hold their value between done pulses. Inputs A, B and sel may change freely after the accept edge without affecting an in-flight MUL.
- sel must be decoded completely; there are no illegal opcodes.

Test Plan:
Defaults WIDTH_A=4, WIDTH_B=2 unless noted.
- Reset: drive rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; busy=0 after release.
- MUL A=7, B=3, start for 1 cycle -> busy=1 for 2 cycles; done in cycle after E0+2; Y=0x5, C=1, Z=0, N=0, V=0. Then A=3, B=2 -> Y=0x6, C=0.
- SUB sequence, each op 1 cycle latency:
  - A=2, B=3 -> Y=0xF, C=1, N=1, V=0, Z=0.
  - A=8, B=1 -> Y=0x7, V=1, C=0, N=0.
  - A=3, B=3 -> Y=0, Z=1, C=0.
- AND/XOR back-to-back (start held high):
  - AND A=0xC, B=3 -> Y=0, Z=1.
  - Next cycle XOR A=0x5, B=2 -> Y=0x7; done high on 2 consecutive cycles.
- Busy protection and abort:
  - During MUL, drive start with sel=01 and change A/B -> ignored; MUL result unchanged.
  - Assert rst_n=0 during MUL cycle 1 -> no done pulse; Y=0.
- Parametrised run WIDTH_A=8, WIDTH_B=4: MUL A=0xFF, B=0xF -> latency 4; Y=0xF1, C=1. Also SUB A=0x00, B=0x1 -> Y=0xFF, C=1, N=1.
